// File: rtl/mips_cpu_load_store_unit.sv
// MIPS load/store unit: turns one core byte/half/word request at a time into an
// Avalon-MM access with lane selection, load extension, alignment checks and a bus timeout.
module mips_cpu_load_store_unit #(
  parameter int ENDIAN         = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        memwrite,
  output logic        memread,
  input  logic        waitrequest,
  output logic [31:0] memwritedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] memreaddata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   memwritedata_q, memwritedata_d;
  logic [3:0]    byteenable_q, byteenable_d;
  logic          memread_q, memread_d;
  logic          memwrite_q, memwrite_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_error_q, resp_error_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] wait_cnt_inc_s;
  logic          bad_req_s;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      2'b00:   m = (ENDIAN == 0) ? (4'b0001 << off) : (4'b1000 >> off);
      2'b01:   m = ((ENDIAN == 0) == (off[1] == 1'b0)) ? 4'b0011 : 4'b1100;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      2'b10:   r = wdata;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Pick the addressed lane(s) out of the bus word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lane = (ENDIAN == 0) ? off : (2'd3 - off);
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = (lane_mask(2'b01, off) == 4'b0011) ? rdata[15:0] : rdata[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = rdata;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign bad_req_s = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign wait_cnt_inc_s = wait_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    wr_d           = wr_q;
    size_d         = size_q;
    sgn_d          = sgn_q;
    off_d          = off_q;
    mem_address_d  = mem_address_q;
    memwritedata_d = memwritedata_q;
    byteenable_d   = byteenable_q;
    memread_d      = memread_q;
    memwrite_d     = memwrite_q;
    wait_cnt_d     = wait_cnt_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = 32'd0;
    resp_error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d       = req_write;
          size_d     = req_size;
          sgn_d      = req_signed;
          off_d      = req_addr[1:0];
          wait_cnt_d = '0;
          if (bad_req_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d        = BUS;
            mem_address_d  = {req_addr[31:2], 2'b00};
            byteenable_d   = lane_mask(req_size, req_addr[1:0]);
            memwritedata_d = store_lanes(req_size, req_wdata);
            memread_d      = ~req_write;
            memwrite_d     = req_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d      = RESP;
          memread_d    = 1'b0;
          memwrite_d   = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = wr_q ? 32'd0 : load_extend(memreaddata, size_q, off_q, sgn_q);
        end else begin
          wait_cnt_d = wait_cnt_inc_s;
          // The access gives up in the cycle the count reaches the limit.
          if (wait_cnt_inc_s == TMO) begin
            state_d      = RESP;
            memread_d    = 1'b0;
            memwrite_d   = 1'b0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d = BUS;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      size_q         <= 2'b00;
      sgn_q          <= 1'b0;
      off_q          <= 2'b00;
      mem_address_q  <= 32'd0;
      memwritedata_q <= 32'd0;
      byteenable_q   <= 4'b0000;
      memread_q      <= 1'b0;
      memwrite_q     <= 1'b0;
      wait_cnt_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'd0;
      resp_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      size_q         <= size_d;
      sgn_q          <= sgn_d;
      off_q          <= off_d;
      mem_address_q  <= mem_address_d;
      memwritedata_q <= memwritedata_d;
      byteenable_q   <= byteenable_d;
      memread_q      <= memread_d;
      memwrite_q     <= memwrite_d;
      wait_cnt_q     <= wait_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_error_q   <= resp_error_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !reset;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_error   = resp_error_q;
  assign mem_address  = mem_address_q;
  assign memwrite     = memwrite_q;
  assign memread      = memread_q;
  assign memwritedata = memwritedata_q;
  assign byteenable   = byteenable_q;

endmodule
